seg7_scan_capture: RTL and testbench
====================================

Name: seg7_scan_capture

Overview:
- Receive-side counterpart of the 4-digit multiplexed 7-segment driver.
- Watches the scanned segment/anode bus, decodes each digit phase back to BCD, and reassembles the 4-digit value as binary 0..9999.
- Used as a self-check monitor in the stopwatch design and as a loopback checker on hardware.

Parameters:
- SETTLE, 4, consecutive cycles the anode+segment pair must be stable before a digit is sampled (min 1).
- STALE_CYC, 1000000, cycles without a completed frame before o_stale asserts.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low.
- i_sseg  in  7  segments {g,f,e,d,c,b,a}, active-low.
- i_an  in  4  digit anodes, active-low one-hot; bit0 = ones digit, bit3 = thousands digit.
- i_dp  in  1  decimal point, active-low; used only with the optional feature.
- o_num  out  16  last complete captured value, binary 0..9999.
- o_valid  out  1  one-cycle pulse when o_num is updated.
- o_err  out  1  one-cycle pulse on an undecodable segment pattern.
- o_stale  out  1  high while no frame has completed for STALE_CYC cycles.
- o_dp  out  4  per-digit decimal point, active-high; see Optional Feature.

Behaviour:
- Reset (rst=0 at a clk edge): o_num=0, o_valid=0, o_err=0, o_stale=0, o_dp=0, digit mask=0, stale counter=0, state IDLE. Reset mid-conversion aborts the conversion with no o_valid pulse.
- Decode table (i_sseg to digit): 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 7F (blank)->0. Any other pattern is invalid.
- Anode handling:
  - Valid anode values are 1110, 1101, 1011, 0111.
  - Any other value (1111 blanking, multi-hot) resets the settle counter. It is not an error.
- States:
  - IDLE: settle counter runs while {i_an,i_sseg} is unchanged and i_an is valid. Any change reloads the counter to 0.
  - SAMPLE: entered once the counter reaches SETTLE-1. Exactly one sample is taken per anode dwell; a new sample needs an anode/segment change plus a fresh settle period.
    - Valid pattern: store the digit in slot[idx] and set mask[idx]. A slot already captured is overwritten.
    - Invalid pattern: o_err pulses, mask clears to 0, return to IDLE.
    - When mask becomes 1111, go to CONVERT. Otherwise return to IDLE.
  - CONVERT: 4 cycles, acc = acc*10 + slot[k] for k=3 down to 0. Use 14-bit arithmetic, computing *10 as (acc<<3)+(acc<<1). Then go to DONE.
  - DONE: o_num<=acc, o_valid=1 for 1 cycle, mask=0, stale counter cleared, return to IDLE.
- Timing and scan behaviour:
  - Latency from the sample of the last missing digit to o_valid is 5 cycles.
  - Scan input is ignored during CONVERT/DONE. A digit missed during that window is picked up on the next scan pass.
- Stale counter:
  - Increments every cycle and saturates at STALE_CYC.
  - o_stale = (counter == STALE_CYC); cleared on o_valid.
- o_num holds its value between frames. o_valid and o_err never assert in the same cycle.

Optional Feature:
- Macro SEG7_CAP_DP_EN.
- Defined: i_dp is sampled with each digit into dp_slot[idx]. o_dp updates together with o_num on o_valid and holds otherwise.
- Undefined: i_dp is unused, o_dp is tied to 4'b0000, and no dp storage is built.

Test Plan:
- Scan 1234 (an 1110/1101/1011/0111 with sseg 19/30/24/79, 8-cycle dwell, SETTLE=4) -> o_valid pulse, o_num=16'h04D2, o_err=0.
- Switch to 5432 (sseg 24/30/19/12) -> next complete frame gives o_num=16'h1538. o_num stays 04D2 until then.
- Inject a 2-cycle glitch pattern 7'h55 on one digit phase, then restore -> no o_err, no sample during the glitch, frame still completes correctly.
- Hold 7'h55 for a full dwell on digit 1 -> o_err one-cycle pulse, mask cleared, next full clean frame restores o_valid.
- Scan blank, blank, 0, 7 (7F, 7F, 40, 78 on digits 3..0) -> o_num=7. Then stop scanning (an=1111) for STALE_CYC cycles (set to 100) -> o_stale=1 at cycle 100. Resume -> o_stale=0 after the next o_valid.
- Assert rst=0 during CONVERT -> no o_valid, all outputs 0.
- With SEG7_CAP_DP_EN, a dp on digit 2 -> o_dp=4'b0100 on o_valid.

Source files
------------

// File: rtl/seg7_scan_capture.sv
// Receive-side monitor for a 4-digit multiplexed 7-segment bus: decodes each settled digit
// phase and reassembles the value as binary. Define SEG7_CAP_DP_EN to capture per-digit decimal points.
module seg7_scan_capture #(
    parameter int SETTLE    = 4,
    parameter int STALE_CYC = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  i_sseg,
    input  logic [3:0]  i_an,
    input  logic        i_dp,
    output logic [15:0] o_num,
    output logic        o_valid,
    output logic        o_err,
    output logic        o_stale,
    output logic [3:0]  o_dp
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int TW = $clog2(STALE_CYC + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [TW-1:0] STALE_MAX   = TW'(STALE_CYC);

    typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, DONE} state_t;

    // Returns {decodable, digit}; a blanked digit reads as 0.
    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        case (s)
            7'h40:   return {1'b1, 4'd0};
            7'h79:   return {1'b1, 4'd1};
            7'h24:   return {1'b1, 4'd2};
            7'h30:   return {1'b1, 4'd3};
            7'h19:   return {1'b1, 4'd4};
            7'h12:   return {1'b1, 4'd5};
            7'h02:   return {1'b1, 4'd6};
            7'h78:   return {1'b1, 4'd7};
            7'h00:   return {1'b1, 4'd8};
            7'h10:   return {1'b1, 4'd9};
            7'h7F:   return {1'b1, 4'd0};
            default: return 5'b0_0000;
        endcase
    endfunction

    function automatic logic an_valid(input logic [3:0] a);
        return (a == 4'b1110) || (a == 4'b1101) || (a == 4'b1011) || (a == 4'b0111);
    endfunction

    function automatic logic [1:0] an_index(input logic [3:0] a);
        case (a)
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            4'b0111: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [13:0] mul10_add(input logic [13:0] acc_in, input logic [3:0] d);
        return (acc_in << 3) + (acc_in << 1) + {10'd0, d};
    endfunction

    function automatic logic [TW-1:0] stale_inc(input logic [TW-1:0] c);
        return (c == STALE_MAX) ? c : c + TW'(1);
    endfunction

    state_t        state;
    logic [SW-1:0] settle_cnt;
    logic          armed;
    logic [3:0]    mask;
    logic [1:0]    k;
    logic          vld_p0;
    logic [TW-1:0] stale_cnt;

    logic [10:0]   prev_p0;
    logic [3:0]    digit_p0;
    logic [1:0]    idx_p0;
    logic [3:0]    slot [4];
    logic [13:0]   acc;

    logic [4:0]    dec;
    logic          stable;
    logic          fire;
    logic [3:0]    idx_oh;

    assign dec     = seg_decode(i_sseg);
    assign stable  = ({i_an, i_sseg} == prev_p0) && an_valid(i_an);
    assign fire    = (state == IDLE) && stable && armed && (settle_cnt == SETTLE_LAST);
    assign idx_oh  = 4'b0001 << idx_p0;
    assign o_stale = (stale_cnt == STALE_MAX);

`ifdef SEG7_CAP_DP_EN
    logic       dp_p0;
    logic [3:0] dp_slot;
`else
    logic unused_dp;
    assign unused_dp = i_dp;
    assign o_dp      = 4'b0000;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            settle_cnt <= '0;
            armed      <= 1'b1;
            mask       <= '0;
            k          <= '0;
            vld_p0     <= 1'b0;
            o_num      <= '0;
            o_valid    <= 1'b0;
            o_err      <= 1'b0;
            stale_cnt  <= '0;
`ifdef SEG7_CAP_DP_EN
            o_dp       <= 4'b0000;
`endif
        end else begin
            o_valid   <= 1'b0;
            o_err     <= 1'b0;
            stale_cnt <= stale_inc(stale_cnt);
            case (state)
                IDLE: begin
                    // armed allows one sample per dwell; any bus change re-arms it
                    if (!stable) begin
                        settle_cnt <= '0;
                        armed      <= 1'b1;
                    end else if (fire) begin
                        state  <= SAMPLE;
                        armed  <= 1'b0;
                        vld_p0 <= dec[4];
                    end else if (settle_cnt != SETTLE_LAST) begin
                        settle_cnt <= settle_cnt + SW'(1);
                    end
                end
                SAMPLE: begin
                    if (vld_p0) begin
                        mask <= mask | idx_oh;
                        if ((mask | idx_oh) == 4'b1111) begin
                            state <= CONVERT;
                            k     <= 2'd3;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        o_err <= 1'b1;
                        mask  <= '0;
                        state <= IDLE;
                    end
                end
                CONVERT: begin
                    k <= k - 2'd1;
                    if (k == 2'd0) state <= DONE;
                end
                DONE: begin
                    o_num     <= {2'b00, acc};
                    o_valid   <= 1'b1;
                    mask      <= '0;
                    stale_cnt <= '0;
                    state     <= IDLE;
`ifdef SEG7_CAP_DP_EN
                    o_dp      <= dp_slot;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ---- p0: sampled digit; slots; MSD-first conversion ----
    always_ff @(posedge clk) begin
        prev_p0 <= {i_an, i_sseg};
        if (fire) begin
            digit_p0 <= dec[3:0];
            idx_p0   <= an_index(i_an);
`ifdef SEG7_CAP_DP_EN
            dp_p0    <= ~i_dp;
`endif
        end
        if (state == SAMPLE && vld_p0) begin
            slot[idx_p0] <= digit_p0;
            acc          <= '0;
`ifdef SEG7_CAP_DP_EN
            dp_slot[idx_p0] <= dp_p0;
`endif
        end
        if (state == CONVERT) acc <= mul10_add(acc, slot[k]);
    end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture (SETTLE=4, STALE_CYC=100); decimal-point
// expectation follows SEG7_CAP_DP_EN.
module tb_seg7_scan_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  i_sseg;
    logic [3:0]  i_an;
    logic        i_dp;
    logic [15:0] o_num;
    logic        o_valid;
    logic        o_err;
    logic        o_stale;
    logic [3:0]  o_dp;

    int errors = 0;
    int checks = 0;
    int vcount = 0;
    int ecount = 0;
    int both   = 0;
    int exp_v  = 0;
    logic [3:0] exp_dp;

    seg7_scan_capture #(.SETTLE(4), .STALE_CYC(100)) dut (
        .clk(clk), .rst(rst), .i_sseg(i_sseg), .i_an(i_an), .i_dp(i_dp),
        .o_num(o_num), .o_valid(o_valid), .o_err(o_err), .o_stale(o_stale), .o_dp(o_dp)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_valid) vcount++;
        if (o_err) ecount++;
        if (o_valid && o_err) both++;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic dwell(input logic [3:0] an, input logic [6:0] seg, input logic dp, input int n);
        @(negedge clk);
        i_an = an; i_sseg = seg; i_dp = ~dp;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic blank(input int n);
        dwell(4'b1111, 7'h7F, 1'b0, n);
    endtask

    task automatic frame(input logic [6:0] s3, input logic [6:0] s2, input logic [6:0] s1,
                         input logic [6:0] s0, input logic [3:0] dpm);
        dwell(4'b1110, s0, dpm[0], 8);
        dwell(4'b1101, s1, dpm[1], 8);
        dwell(4'b1011, s2, dpm[2], 8);
        dwell(4'b0111, s3, dpm[3], 8);
    endtask

    // Blanks the bus and returns on the negedge where o_valid is seen (bounded).
    task automatic wait_valid(input string tag);
        bit seen = 1'b0;
        @(negedge clk);
        i_an = 4'b1111; i_sseg = 7'h7F; i_dp = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (o_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        exp_v++;
        check(tag, 16'(seen), 16'd1);
    endtask

    initial begin
        rst = 1'b0; i_an = 4'b1111; i_sseg = 7'h7F; i_dp = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_num", o_num, 16'h0000);
        check("rst_valid", 16'(o_valid), 16'd0);
        check("rst_err", 16'(o_err), 16'd0);
        check("rst_stale", 16'(o_stale), 16'd0);
        check("rst_dp", 16'(o_dp), 16'd0);
        rst = 1'b1;
        blank(4);

        // 1234
        frame(7'h79, 7'h24, 7'h30, 7'h19, 4'b0000);
        wait_valid("v1234");
        check("num1234", o_num, 16'h04D2);
        blank(20);
        check("err_none1", 16'(ecount), 16'd0);
        check("vcnt1", 16'(vcount), 16'(exp_v));

        // 5432, value holds until the frame completes
        dwell(4'b1110, 7'h24, 1'b0, 8);
        dwell(4'b1101, 7'h30, 1'b0, 8);
        dwell(4'b1011, 7'h19, 1'b0, 8);
        blank(20);
        check("hold_num", o_num, 16'h04D2);
        check("hold_vcnt", 16'(vcount), 16'(exp_v));
        dwell(4'b0111, 7'h12, 1'b0, 8);
        wait_valid("v5432");
        check("num5432", o_num, 16'h1538);

        // 2-cycle glitch on digit 1, then clean
        dwell(4'b1110, 7'h19, 1'b0, 8);
        dwell(4'b1101, 7'h55, 1'b0, 2);
        dwell(4'b1101, 7'h30, 1'b0, 6);
        dwell(4'b1011, 7'h24, 1'b0, 8);
        dwell(4'b0111, 7'h79, 1'b0, 8);
        wait_valid("v_glitch");
        check("num_glitch", o_num, 16'h04D2);
        blank(10);
        check("err_glitch", 16'(ecount), 16'd0);

        // invalid pattern for a full dwell on digit 1
        dwell(4'b1110, 7'h02, 1'b0, 8);
        dwell(4'b1101, 7'h55, 1'b0, 8);
        blank(20);
        check("err_pulse", 16'(ecount), 16'd1);
        check("err_vcnt", 16'(vcount), 16'(exp_v));
        check("err_num", o_num, 16'h04D2);
        dwell(4'b1101, 7'h78, 1'b0, 8);
        dwell(4'b1011, 7'h00, 1'b0, 8);
        dwell(4'b0111, 7'h10, 1'b0, 8);
        blank(20);
        check("mask_cleared", 16'(vcount), 16'(exp_v));
        dwell(4'b1110, 7'h02, 1'b0, 8);
        wait_valid("v9876");
        check("num9876", o_num, 16'h2694);

        // blank, blank, 0, 7 then stale detection
        frame(7'h7F, 7'h7F, 7'h40, 7'h78, 4'b0000);
        wait_valid("v0007");
        check("num0007", o_num, 16'h0007);
        repeat (99) @(negedge clk);
        check("stale_99", 16'(o_stale), 16'd0);
        @(negedge clk);
        check("stale_100", 16'(o_stale), 16'd1);
        repeat (30) @(negedge clk);
        check("stale_hold", 16'(o_stale), 16'd1);
        frame(7'h79, 7'h24, 7'h30, 7'h19, 4'b0100);
        wait_valid("v_resume");
        check("stale_clr", 16'(o_stale), 16'd0);
        check("num_resume", o_num, 16'h04D2);
`ifdef SEG7_CAP_DP_EN
        exp_dp = 4'b0100;
`else
        exp_dp = 4'b0000;
`endif
        check("dp_out", 16'(o_dp), 16'(exp_dp));

        // reset during CONVERT
        dwell(4'b1110, 7'h24, 1'b0, 8);
        dwell(4'b1101, 7'h30, 1'b0, 8);
        dwell(4'b1011, 7'h19, 1'b0, 8);
        dwell(4'b0111, 7'h12, 1'b0, 7);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1; i_an = 4'b1111; i_sseg = 7'h7F; i_dp = 1'b1;
        check("mid_rst_num", o_num, 16'h0000);
        check("mid_rst_valid", 16'(o_valid), 16'd0);
        check("mid_rst_err", 16'(o_err), 16'd0);
        check("mid_rst_stale", 16'(o_stale), 16'd0);
        check("mid_rst_dp", 16'(o_dp), 16'd0);
        blank(20);
        check("mid_rst_novalid", 16'(vcount), 16'(exp_v));
        dwell(4'b1110, 7'h78, 1'b0, 8);
        blank(20);
        check("rst_mask", 16'(vcount), 16'(exp_v));
        dwell(4'b1101, 7'h12, 1'b0, 8);
        dwell(4'b1011, 7'h19, 1'b0, 8);
        dwell(4'b0111, 7'h30, 1'b0, 8);
        wait_valid("v3457");
        check("num3457", o_num, 16'h0D81);
        blank(10);
        check("vcnt_final", 16'(vcount), 16'(exp_v));
        check("err_final", 16'(ecount), 16'd1);
        check("valid_err_excl", 16'(both), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
